// File: rtl/uart_result_streamer.sv
// Latches an ALU result and op code, converts the result to five decimal
// digits by repeated subtraction, then streams "<op>:<ddddd>\n" to a UART.
module uart_result_streamer #(
    parameter int RES_W         = 15,
    parameter int DBITS         = 8,
    parameter bit LEADING_ZEROS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [RES_W-1:0] result,
    input  logic [2:0]       op_sel,
    output logic [DBITS-1:0] tx_data,
    output logic             tx_start,
    input  logic             tx_done,
    output logic             busy,
    output logic             done
);
    localparam int REM_W = (RES_W > 17) ? RES_W : 17;

    typedef enum logic [2:0] {
        IDLE, CONV, LOAD, SEND, WAIT, FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [2:0]       op_q, op_d;
    logic [2:0]       k_q, k_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       i_q, i_d;
    logic [4:0][3:0]  dig_q, dig_d;
    logic [DBITS-1:0] tx_data_q, tx_data_d;

    logic [REM_W-1:0] weight;
    logic             take;
    logic [23:0]      mnem;
    logic [4:0][7:0]  chr;
    logic             lead;
    logic [7:0]       byte_sel;

    // Decimal weight of the digit under conversion; d4 saturates at 9
    always_comb begin
        unique case (k_q)
            3'd4:    weight = REM_W'(10000);
            3'd3:    weight = REM_W'(1000);
            3'd2:    weight = REM_W'(100);
            3'd1:    weight = REM_W'(10);
            default: weight = REM_W'(1);
        endcase
        take = (rem_q >= weight) && (cnt_q != 4'd9);
    end

    // Message byte selected by the byte index
    always_comb begin
        unique case (op_q)
            3'd1:    mnem = "add";
            3'd2:    mnem = "sub";
            3'd3:    mnem = "mul";
            3'd4:    mnem = "div";
            default: mnem = "???";
        endcase
        lead = 1'b1;
        for (int j = 4; j >= 0; j--) begin
            lead   = lead && (dig_q[j] == 4'd0) && (j != 0);
            chr[j] = (lead && !LEADING_ZEROS) ? 8'h20 : {4'h3, dig_q[j]};
        end
        unique case (i_q)
            4'd0:    byte_sel = mnem[23:16];
            4'd1:    byte_sel = mnem[15:8];
            4'd2:    byte_sel = mnem[7:0];
            4'd3:    byte_sel = 8'h3A;
            4'd4:    byte_sel = chr[4];
            4'd5:    byte_sel = chr[3];
            4'd6:    byte_sel = chr[2];
            4'd7:    byte_sel = chr[1];
            4'd8:    byte_sel = chr[0];
            default: byte_sel = 8'h0A;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CONV;
            CONV:    if (!take && k_q == 3'd0) state_d = LOAD;
            LOAD:    state_d = SEND;
            SEND:    state_d = WAIT;
            WAIT:    if (tx_done) state_d = (i_q == 4'd9) ? FINISH : LOAD;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch, convert, walk the byte index
    always_comb begin
        rem_d     = rem_q;
        op_d      = op_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        i_d       = i_q;
        dig_d     = dig_q;
        tx_data_d = tx_data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d = REM_W'(result);
                    op_d  = op_sel;
                    k_d   = 3'd4;
                    cnt_d = 4'd0;
                    i_d   = 4'd0;
                end
            end
            CONV: begin
                if (take) begin
                    rem_d = rem_q - weight;
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    dig_d[k_q] = cnt_q;
                    cnt_d      = 4'd0;
                    if (k_q != 3'd0) k_d = k_q - 3'd1;
                    else             i_d = 4'd0;
                end
            end
            LOAD: tx_data_d = DBITS'(byte_sel);
            WAIT: if (tx_done && i_q != 4'd9) i_d = i_q + 4'd1;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q     <= '0;
            op_q      <= '0;
            k_q       <= '0;
            cnt_q     <= '0;
            i_q       <= '0;
            dig_q     <= '0;
            tx_data_q <= '0;
        end else begin
            rem_q     <= rem_d;
            op_q      <= op_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            i_q       <= i_d;
            dig_q     <= dig_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Outputs decoded from state
    always_comb begin
        tx_data  = tx_data_q;
        tx_start = (state_q == SEND);
        busy     = (state_q != IDLE) && (state_q != FINISH);
        done     = (state_q == FINISH);
    end
endmodule

// File: tb/tb_uart_result_streamer.sv
// Random and directed messages checked against a string-formatting model;
// two instances cover both leading-zero modes on the same stimulus.
module tb_uart_result_streamer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [14:0] result;
    logic [2:0]  op_sel;
    logic        tx_done;
    logic [7:0]  tx_data_a, tx_data_b;
    logic        tx_start_a, tx_start_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_result_streamer #(.RES_W(15), .DBITS(8), .LEADING_ZEROS(1'b1)) u_a (
        .clk(clk), .reset(reset), .start(start), .result(result),
        .op_sel(op_sel), .tx_data(tx_data_a), .tx_start(tx_start_a),
        .tx_done(tx_done), .busy(busy_a), .done(done_a)
    );

    uart_result_streamer #(.RES_W(15), .DBITS(8), .LEADING_ZEROS(1'b0)) u_b (
        .clk(clk), .reset(reset), .start(start), .result(result),
        .op_sel(op_sel), .tx_data(tx_data_b), .tx_start(tx_start_b),
        .tx_done(tx_done), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_msg(input logic [2:0] op, input int val, input int lat,
                           input bit noise, input bit abort);
        string mn, msg_a, msg_b;
        int conv, v, n_tx, done_at, finish_cyc, n_done, exp_tx, abort_cyc;
        bit bad, aborted, finished, exp_busy;
        logic [7:0] last_byte;
        case (op)
            3'd1:    mn = "add";
            3'd2:    mn = "sub";
            3'd3:    mn = "mul";
            3'd4:    mn = "div";
            default: mn = "???";
        endcase
        msg_a = {mn, ":", $sformatf("%05d", val), "\n"};
        msg_b = {mn, ":", $sformatf("%5d", val), "\n"};
        conv = 5;
        v = val;
        while (v > 0) begin
            conv += v % 10;
            v /= 10;
        end
        @(negedge clk);
        start   = 1'b1;
        result  = 15'(val);
        op_sel  = op;
        tx_done = 1'b0;
        exp_tx = conv + 2;
        done_at = -1;
        finish_cyc = 1 << 30;
        abort_cyc = -1;
        n_tx = 0;
        n_done = 0;
        bad = 1'b0;
        aborted = 1'b0;
        finished = 1'b0;
        last_byte = 8'h00;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            start   = 1'b0;
            tx_done = 1'b0;
            reset   = 1'b0;
            if (tx_start_a) begin
                if (n_tx < 10) begin
                    chk("tx_cycle", c, exp_tx);
                    chk("byte_lz1", tx_data_a, 32'(msg_a[n_tx]));
                    chk("byte_lz0", tx_data_b, 32'(msg_b[n_tx]));
                end
                last_byte = tx_data_a;
                done_at = c + lat;
                exp_tx = done_at + 2;
                n_tx++;
                if (n_tx == 10) finish_cyc = done_at + 1;
                if (abort && n_tx == 6) abort_cyc = c + 1;
            end else if (n_tx > 0 && !(aborted && c > abort_cyc) &&
                         tx_data_a !== last_byte) begin
                bad = 1'b1;
            end
            if (done_a) begin
                n_done++;
                chk("done_cycle", c, finish_cyc);
            end
            if (c == finish_cyc + 1)
                chk("tx_hold", tx_data_a, 8'h0A);
            if (aborted && c == abort_cyc + 1) begin
                chk("abort_busy", busy_a, 0);
                chk("abort_txs", tx_start_a, 0);
            end
            exp_busy = (c < finish_cyc) && !(aborted && c > abort_cyc);
            if (busy_a !== exp_busy || busy_b !== exp_busy ||
                tx_start_b !== tx_start_a || done_b !== done_a)
                bad = 1'b1;
            if (!abort && c >= finish_cyc + 2) begin
                finished = 1'b1;
                break;
            end
            if (aborted && c >= done_at + 4) begin
                finished = 1'b1;
                break;
            end
            if (c == done_at) tx_done = 1'b1;
            if (c == abort_cyc) begin
                reset = 1'b1;
                aborted = 1'b1;
            end
            if (noise) begin
                result = 15'($urandom);
                op_sel = 3'($urandom);
                if (c == 2 || c == conv + 4 || c == finish_cyc) start = 1'b1;
                if (done_at >= 0 && c == done_at + 1) tx_done = 1'b1;
                if (c == 3) tx_done = 1'b1;
            end
        end
        chk("complete", finished, 1);
        chk("ctl_ok", bad, 0);
        if (abort) begin
            chk("n_tx_abort", n_tx, 6);
            chk("n_done_abort", n_done, 0);
        end else begin
            chk("n_tx", n_tx, 10);
            chk("n_done", n_done, 1);
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        result  = '0;
        op_sel  = '0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_data", tx_data_a, 0);
        chk("rst_tx_start", tx_start_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        reset = 1'b0;
        @(negedge clk);

        run_msg(3'd1, 12345, 20, 1'b0, 1'b0);
        run_msg(3'd3, 32767, 7, 1'b0, 1'b0);
        run_msg(3'd3, 0, 3, 1'b0, 1'b0);
        run_msg(3'd2, 7, 5, 1'b0, 1'b0);
        run_msg(3'd2, 0, 1, 1'b0, 1'b0);
        run_msg(3'd6, 100, 4, 1'b0, 1'b0);
        run_msg(3'd4, 9876, 6, 1'b1, 1'b0);
        run_msg(3'd1, 31415, 20, 1'b0, 1'b1);
        run_msg(3'd5, 2024, 3, 1'b0, 1'b0);
        for (int n = 0; n < 12; n++) begin
            run_msg(3'($urandom_range(0, 7)), int'($urandom_range(0, 32767)),
                    int'($urandom_range(2, 25)), 1'($urandom_range(0, 1)),
                    1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
